// File: rtl/mul_iterative_unit.sv
// rtl/mul_iterative_unit.sv - iterative shift-add multiplier for the Execute stage
// Retires BITS_PER_CYCLE multiplier bits per BUSY cycle and stalls the pipeline until the product is ready.
module mul_iterative_unit #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             x_mul_req,
   input  logic             x_advance,
   input  logic             x_flush,
   input  logic [WIDTH-1:0] x_op_a,
   input  logic [WIDTH-1:0] x_op_b,
   output logic             x_alu_ready,
   output logic             x_mul_busy,
   output logic [WIDTH-1:0] x_mul_result
);

   localparam int N_ITER = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               busy_q, busy_d;
   logic [WIDTH-1:0]   step_sum;

   always_comb begin
      step_sum = '0;
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
         if (mplier_q[k]) begin
            step_sum = step_sum + (mcand_q << k);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      result_d = result_q;

      case (state_q)
         ST_IDLE: begin
            if (x_mul_req && !x_flush) begin
               mcand_d  = x_op_a;
               mplier_d = x_op_b;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // A flush or a vanished request abandons the partial product.
            if (x_flush || !x_mul_req) begin
               state_d = ST_IDLE;
            end else begin
               acc_d    = acc_q + step_sum;
               mcand_d  = mcand_q << BITS_PER_CYCLE;
               mplier_d = mplier_q >> BITS_PER_CYCLE;
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(N_ITER - 1)) begin
                  result_d = acc_q + step_sum;
                  state_d  = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (x_flush || x_advance || !x_mul_req) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_BUSY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         busy_q   <= busy_d;
      end
   end

   assign x_alu_ready  = ~x_mul_req | (state_q == ST_DONE);
   assign x_mul_busy   = busy_q;
   assign x_mul_result = result_q;

endmodule

// File: tb/tb_mul_iterative_unit.sv
// tb/tb_mul_iterative_unit.sv - directed self-checking bench for mul_iterative_unit
// Drives inputs just after rising edges and samples outputs on falling edges.
module tb_mul_iterative_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        x_mul_req;
   logic        x_advance;
   logic        x_flush;
   logic [31:0] x_op_a;
   logic [31:0] x_op_b;
   logic        rdy1, busy1;
   logic [31:0] res1;
   logic        rdy4, busy4;
   logic [31:0] res4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mul_iterative_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .x_mul_req    (x_mul_req),
      .x_advance    (x_advance),
      .x_flush      (x_flush),
      .x_op_a       (x_op_a),
      .x_op_b       (x_op_b),
      .x_alu_ready  (rdy1),
      .x_mul_busy   (busy1),
      .x_mul_result (res1)
   );

   mul_iterative_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
      .clk          (clk),
      .rst_n        (rst_n),
      .x_mul_req    (x_mul_req),
      .x_advance    (x_advance),
      .x_flush      (x_flush),
      .x_op_a       (x_op_a),
      .x_op_b       (x_op_b),
      .x_alu_ready  (rdy4),
      .x_mul_busy   (busy4),
      .x_mul_result (res4)
   );

   // Raises req in the current cycle (cycle 0), counts cycles with ready low,
   // captures the result in the first ready cycle and advances out of X.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit use4,
                         output int lat, output logic [31:0] res, output logic busy_mid);
      x_op_a    = a;
      x_op_b    = b;
      x_mul_req = 1'b1;
      lat       = 0;
      busy_mid  = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (lat == 5) busy_mid = use4 ? busy4 : busy1;
         if ((use4 ? rdy4 : rdy1) === 1'b1) break;
         lat++;
         @(posedge clk);
         #1;
      end
      res       = use4 ? res4 : res1;
      x_advance = 1'b1;
      @(posedge clk);
      #1;
      x_advance = 1'b0;
   endtask

   task automatic idle_cycle();
      x_mul_req = 1'b0;
      x_flush   = 1'b0;
      x_advance = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      x_mul_req = 1'b0;
      x_advance = 1'b0;
      x_flush   = 1'b0;
      x_op_a    = '0;
      x_op_b    = '0;
      @(negedge clk);
      checks++;
      if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", rdy1); end
      checks++;
      if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy1); end
      checks++;
      if (res1 !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", res1); end
      x_mul_req = 1'b1;
      #1;
      checks++;
      if (rdy1 !== 1'b0) begin errors++; $display("FAIL reset_ready_req: got %b expected 0", rdy1); end
      x_mul_req = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_cycle();
   endtask

   task automatic test_basic();
      int lat; logic [31:0] r; logic bm;
      run_op(32'd6, 32'd7, 1'b0, lat, r, bm);
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL basic_latency: got %0d expected 33", lat); end
      checks++;
      if (r !== 32'd42) begin errors++; $display("FAIL basic_result: got %0d expected 42", r); end
      checks++;
      if (bm !== 1'b1) begin errors++; $display("FAIL basic_busy_mid: got %b expected 1", bm); end
      x_mul_req = 1'b0;
      @(negedge clk);
      checks++;
      if (busy1 !== 1'b0 || rdy1 !== 1'b1) begin
         errors++; $display("FAIL basic_after_adv: busy %b ready %b expected busy 0 ready 1", busy1, rdy1);
      end
      checks++;
      if (res1 !== 32'd42) begin errors++; $display("FAIL basic_hold: got %0d expected 42", res1); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_wrap();
      int lat; logic [31:0] r; logic bm;
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, r, bm);
      checks++;
      if (r !== 32'h0000_0001) begin errors++; $display("FAIL wrap_ffff: got %h expected 00000001", r); end
      idle_cycle();
      run_op(32'h8000_0000, 32'd2, 1'b0, lat, r, bm);
      checks++;
      if (r !== 32'h0000_0000) begin errors++; $display("FAIL wrap_msb: got %h expected 00000000", r); end
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL wrap_latency: got %0d expected 33", lat); end
      idle_cycle();
   endtask

   task automatic test_bpc4();
      int lat; logic [31:0] r; logic bm;
      run_op(32'h1234_5678, 32'h9, 1'b1, lat, r, bm);
      checks++;
      if (lat !== 9) begin errors++; $display("FAIL bpc4_latency: got %0d expected 9", lat); end
      checks++;
      if (r !== 32'hA3D7_0A38) begin errors++; $display("FAIL bpc4_result: got %h expected a3d70a38", r); end
      idle_cycle();
      idle_cycle();
   endtask

   task automatic test_back_to_back();
      int lat; logic [31:0] r; logic bm;
      run_op(32'd3, 32'd5, 1'b0, lat, r, bm);
      checks++;
      if (r !== 32'd15) begin errors++; $display("FAIL b2b_first: got %0d expected 15", r); end
      run_op(32'h0000_FFFF, 32'h0001_0001, 1'b0, lat, r, bm);
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
      checks++;
      if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_second: got %h expected ffffffff", r); end
      idle_cycle();
   endtask

   task automatic test_flush();
      int lat; logic [31:0] r; logic bm;
      x_op_a    = 32'd9;
      x_op_b    = 32'd9;
      x_mul_req = 1'b1;
      repeat (10) begin @(posedge clk); #1; end
      x_flush = 1'b1;
      @(posedge clk);
      #1;
      x_flush   = 1'b0;
      x_mul_req = 1'b0;
      @(negedge clk);
      checks++;
      if (busy1 !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy1); end
      checks++;
      if (res1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL flush_hold: got %h expected ffffffff", res1); end
      @(posedge clk);
      #1;
      run_op(32'd2, 32'd3, 1'b0, lat, r, bm);
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL flush_new_latency: got %0d expected 33", lat); end
      checks++;
      if (r !== 32'd6) begin errors++; $display("FAIL flush_new_result: got %0d expected 6", r); end
      idle_cycle();
      // Flush on the last BUSY cycle must suppress the result write.
      x_op_a    = 32'd5;
      x_op_b    = 32'd5;
      x_mul_req = 1'b1;
      repeat (32) begin @(posedge clk); #1; end
      x_flush = 1'b1;
      @(posedge clk);
      #1;
      x_flush = 1'b0;
      @(negedge clk);
      checks++;
      if (rdy1 !== 1'b0 || busy1 !== 1'b0) begin
         errors++; $display("FAIL flush_last: ready %b busy %b expected ready 0 busy 0", rdy1, busy1);
      end
      checks++;
      if (res1 !== 32'd6) begin errors++; $display("FAIL flush_last_result: got %0d expected 6", res1); end
      @(posedge clk);
      #1;
      idle_cycle();
   endtask

   task automatic test_reset_mid();
      x_op_a    = 32'd7;
      x_op_b    = 32'd7;
      x_mul_req = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy1 !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy1); end
      checks++;
      if (res1 !== 32'h0) begin errors++; $display("FAIL rstmid_result: got %h expected 0", res1); end
      checks++;
      if (rdy1 !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b expected 0", rdy1); end
      x_mul_req = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_cycle();
   endtask

   task automatic test_idle();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (rdy1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++; $display("FAIL idle_noreq: cycle %0d ready %b busy %b expected ready 1 busy 0", i, rdy1, busy1);
         end
         @(posedge clk);
         #1;
      end
      x_mul_req = 1'b1;
      x_flush   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         checks++;
         if (busy1 !== 1'b0 || rdy1 !== 1'b0) begin
            errors++; $display("FAIL idle_flush_start: cycle %0d busy %b ready %b expected busy 0 ready 0", i, busy1, rdy1);
         end
      end
      @(posedge clk);
      #1;
      x_flush = 1'b0;
      // Dropping req mid-BUSY aborts without writing a result.
      x_op_a = 32'd11;
      x_op_b = 32'd11;
      repeat (6) begin @(posedge clk); #1; end
      x_mul_req = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (busy1 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy1); end
      checks++;
      if (res1 !== 32'h0) begin errors++; $display("FAIL abort_result: got %h expected 0", res1); end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_bpc4();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
